// File: rtl/midi_note_decoder.sv
// Monophonic MIDI note decoder: turns a channel-filtered byte stream into note/velocity/gate outputs.
// Optional build macro MIDI_RUNNING_STATUS_EN keeps the message type after each note so data pairs repeat it.
module midi_note_decoder #(
  parameter logic [3:0] CHANNEL = 4'h0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] i_data,
  input  logic       i_valid,
  output logic       o_cmd,
  output logic [6:0] o_midi,
  output logic [6:0] o_velocity,
  output logic       o_note_on
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_NOTE = 2'd1,
    WAIT_VEL  = 2'd2,
    SKIP      = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic       type_on_q, type_on_d;
  logic [6:0] note_q, note_d;
  logic       cmd_q, cmd_d;
  logic [6:0] midi_q, midi_d;
  logic [6:0] vel_q, vel_d;
  logic       note_on_q, note_on_d;

  logic is_status;
  logic is_our_note_msg;

  assign is_status       = i_data[7];
  assign is_our_note_msg = (i_data[6:5] == 2'b00) && (i_data[3:0] == CHANNEL);

  always_comb begin
    state_d   = state_q;
    type_on_d = type_on_q;
    note_d    = note_q;
    cmd_d     = cmd_q;
    midi_d    = midi_q;
    vel_d     = vel_q;
    note_on_d = 1'b0;

    if (i_valid) begin
      if (is_status) begin
        // Real-time bytes (F8-FF) fall through every branch and change nothing.
        if (is_our_note_msg) begin
          type_on_d = i_data[4];
          state_d   = WAIT_NOTE;
        end else if (i_data < 8'hF0) begin
          state_d = SKIP;
        end else if (i_data < 8'hF8) begin
          state_d = IDLE;
        end
      end else begin
        case (state_q)
          WAIT_NOTE: begin
            note_d  = i_data[6:0];
            state_d = WAIT_VEL;
          end
          WAIT_VEL: begin
            if (type_on_q && (i_data[6:0] != 7'd0)) begin
              midi_d    = note_q;
              vel_d     = i_data[6:0];
              cmd_d     = 1'b1;
              note_on_d = 1'b1;
            end else if (note_q == midi_q) begin
              cmd_d = 1'b0;
            end
`ifdef MIDI_RUNNING_STATUS_EN
            state_d = WAIT_NOTE;
`else
            state_d = IDLE;
`endif
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      type_on_q <= 1'b0;
      note_q    <= '0;
      cmd_q     <= 1'b0;
      midi_q    <= '1;
      vel_q     <= '0;
      note_on_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      type_on_q <= type_on_d;
      note_q    <= note_d;
      cmd_q     <= cmd_d;
      midi_q    <= midi_d;
      vel_q     <= vel_d;
      note_on_q <= note_on_d;
    end
  end

  assign o_cmd      = cmd_q;
  assign o_midi     = midi_q;
  assign o_velocity = vel_q;
  assign o_note_on  = note_on_q;

endmodule

// File: tb/tb_midi_note_decoder.sv
// Directed self-checking bench for midi_note_decoder (CHANNEL=0); expectations follow MIDI_RUNNING_STATUS_EN.
module tb_midi_note_decoder;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] i_data;
  logic       i_valid;
  logic       o_cmd;
  logic [6:0] o_midi;
  logic [6:0] o_velocity;
  logic       o_note_on;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  logic mon_en = 1'b0;
  logic cmd_dropped = 1'b0;

  midi_note_decoder #(.CHANNEL(4'h0)) dut (
    .clk        (clk),
    .reset      (reset),
    .i_data     (i_data),
    .i_valid    (i_valid),
    .o_cmd      (o_cmd),
    .o_midi     (o_midi),
    .o_velocity (o_velocity),
    .o_note_on  (o_note_on)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (o_note_on) pulses <= pulses + 1;
    if (mon_en && !o_cmd) cmd_dropped <= 1'b1;
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Byte is presented at a falling edge; outputs are valid at the next falling edge.
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    i_data  = b;
    i_valid = 1'b1;
    @(negedge clk);
    i_valid = 1'b0;
    i_data  = 8'h00;
  endtask

  int p0;

  initial begin
    reset   = 1'b1;
    i_data  = 8'h00;
    i_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cmd", {7'd0, o_cmd}, 8'h00);
    check("rst_midi", {1'b0, o_midi}, 8'h7F);
    check("rst_vel", {1'b0, o_velocity}, 8'h00);
    check("rst_pulse", {7'd0, o_note_on}, 8'h00);
    reset = 1'b0;

    // Basic note-on
    send(8'h90); send(8'h45);
    check("pre_vel_cmd", {7'd0, o_cmd}, 8'h00);
    send(8'h64);
    check("on_pulse", {7'd0, o_note_on}, 8'h01);
    check("on_cmd", {7'd0, o_cmd}, 8'h01);
    check("on_midi", {1'b0, o_midi}, 8'h45);
    check("on_vel", {1'b0, o_velocity}, 8'h64);
    @(negedge clk);
    check("on_pulse_end", {7'd0, o_note_on}, 8'h00);
    check("on_pulse_count", pulses[7:0], 8'd1);

    // Note-off for a different note is ignored; matching one clears
    send(8'h80); send(8'h40); send(8'h00);
    check("off_other_cmd", {7'd0, o_cmd}, 8'h01);
    send(8'h80); send(8'h45); send(8'h00);
    check("off_match_cmd", {7'd0, o_cmd}, 8'h00);
    check("off_midi_kept", {1'b0, o_midi}, 8'h45);
    check("off_vel_kept", {1'b0, o_velocity}, 8'h64);

    // Retarget with interleaved real-time bytes
    p0 = pulses;
    send(8'h90); send(8'h45); send(8'h64);
    mon_en = 1'b1;
    send(8'hF8); send(8'h90); send(8'hF8); send(8'h48); send(8'hF8); send(8'h20);
    @(negedge clk);
    mon_en = 1'b0;
    check("rt_midi", {1'b0, o_midi}, 8'h48);
    check("rt_vel", {1'b0, o_velocity}, 8'h20);
    check("rt_cmd_continuous", {7'd0, cmd_dropped}, 8'h00);
    check("rt_pulse_count", 8'(pulses - p0), 8'd2);

    // Running status: 45 00 after a complete note-on
    send(8'h90); send(8'h45); send(8'h64);
    check("rs_midi", {1'b0, o_midi}, 8'h45);
    send(8'h45); send(8'h00);
`ifdef MIDI_RUNNING_STATUS_EN
    check("rs_cmd", {7'd0, o_cmd}, 8'h00);
`else
    check("rs_cmd", {7'd0, o_cmd}, 8'h01);
`endif

    // Velocity-0 note-on acts as note-off
    send(8'h90); send(8'h45); send(8'h00);
    check("v0_off_cmd", {7'd0, o_cmd}, 8'h00);
    check("v0_off_vel", {1'b0, o_velocity}, 8'h64);

    // Other channel / other message type produce no change
    p0 = pulses;
    send(8'h91); send(8'h45); send(8'h64);
    send(8'hB0); send(8'h07); send(8'h7F);
    check("skip_cmd", {7'd0, o_cmd}, 8'h00);
    check("skip_midi", {1'b0, o_midi}, 8'h45);
    check("skip_vel", {1'b0, o_velocity}, 8'h64);
    check("skip_pulses", 8'(pulses - p0), 8'd0);

    // System common aborts a partial message
    send(8'h90); send(8'h45); send(8'hF0); send(8'h64);
    check("sys_abort_cmd", {7'd0, o_cmd}, 8'h00);

    // New status mid-message restarts parsing
    send(8'h90); send(8'h30); send(8'h90); send(8'h31); send(8'h22);
    check("restart_midi", {1'b0, o_midi}, 8'h31);
    check("restart_vel", {1'b0, o_velocity}, 8'h22);

    // Note 127 is passed through unclamped
    send(8'h90); send(8'h7F); send(8'h01);
    check("n127_midi", {1'b0, o_midi}, 8'h7F);
    check("n127_vel", {1'b0, o_velocity}, 8'h01);
    check("n127_cmd", {7'd0, o_cmd}, 8'h01);

    // Reset coincident with the velocity byte wins
    send(8'h90); send(8'h45);
    @(negedge clk);
    reset   = 1'b1;
    i_data  = 8'h64;
    i_valid = 1'b1;
    @(negedge clk);
    reset   = 1'b0;
    i_valid = 1'b0;
    check("rstmsg_midi", {1'b0, o_midi}, 8'h7F);
    check("rstmsg_cmd", {7'd0, o_cmd}, 8'h00);
    check("rstmsg_pulse", {7'd0, o_note_on}, 8'h00);
    send(8'h64);
    check("rstmsg_late_data", {7'd0, o_cmd}, 8'h00);
    check("rstmsg_late_midi", {1'b0, o_midi}, 8'h7F);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/midi_note_decoder.md
MIDI_NOTE_DECODER -- requirements
Module: midi_note_decoder

Interface
REQ-001 SHALL have parameter CHANNEL, default 4'h0, which sets the MIDI channel (0-15) the block responds to.
REQ-002 SHALL have port clk, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port i_data, input, 8 bits: received MIDI byte from the UART receiver.
REQ-005 SHALL have port i_valid, input, 1 bit: one-cycle strobe marking i_data valid; every strobe is one byte.
REQ-006 SHALL have port o_cmd, output, 1 bit: note-active level, driving the phase bank run/stop command.
REQ-007 SHALL have port o_midi, output, 7 bits: current note number for the tuning-word lookup.
REQ-008 SHALL have port o_velocity, output, 7 bits: velocity of the last accepted note-on.
REQ-009 SHALL have port o_note_on, output, 1 bit: one-cycle pulse on every accepted note-on.

Function
REQ-010 SHALL classify each valid byte: bit7=1 is a status byte; bit7=0 is a data byte.
REQ-011 SHALL use FSM states IDLE, WAIT_NOTE, WAIT_VEL and SKIP; IDLE means no running status.
REQ-012 Status 8n/9n with n==CHANNEL SHALL latch the message type (off/on) and go to WAIT_NOTE.
REQ-013 Any other status in 80-EF (other channel or other message type) SHALL go to SKIP.
REQ-014 Status F0-F7 SHALL go to IDLE and clear running status.
REQ-015 Real-time bytes F8-FF SHALL be ignored, leaving state, latched type and held note unchanged.
REQ-016 In IDLE and SKIP, data bytes SHALL be discarded.
REQ-017 A data byte in WAIT_NOTE SHALL be latched as the pending note, then the FSM SHALL go to WAIT_VEL.
REQ-018 A data byte in WAIT_VEL SHALL complete the message; outputs update on the clock edge after that byte's strobe (latency 1).
REQ-019 Note-on with velocity>0: o_midi <= note, o_velocity <= velocity, o_cmd <= 1 and o_note_on pulses for 1 cycle.
REQ-020 Note-on with velocity 0 SHALL be treated exactly as note-off.
REQ-021 Note-off SHALL clear o_cmd only when its note equals o_midi; otherwise it is ignored.
REQ-022 Note-off SHALL never change o_midi or o_velocity.
REQ-023 Note-on while o_cmd=1 SHALL retarget o_midi, keep o_cmd high without a low cycle, and pulse o_note_on (last-note priority, monophonic).
REQ-024 Note 127 SHALL be accepted as normal; no clamping is applied.
REQ-025 A status byte arriving in WAIT_NOTE or WAIT_VEL SHALL abort the partial message and be processed as a new status.

Reset
REQ-026 Reset SHALL set state IDLE, o_cmd=0, o_midi=7'h7f, o_velocity=0, o_note_on=0 and clear running status.
REQ-027 Reset SHALL take priority over i_valid in the same cycle; a message in progress is discarded.

Configuration
REQ-028 When macro MIDI_RUNNING_STATUS_EN is defined, completing a message in WAIT_VEL SHALL return the FSM to WAIT_NOTE with the same type, so further data pairs act as new messages.
REQ-029 Without MIDI_RUNNING_STATUS_EN, completing a message SHALL return the FSM to IDLE, and data bytes without a fresh status are discarded.

Verification
REQ-030 90 45 64 -> one cycle after the last byte: o_cmd=1, o_midi=45h, o_velocity=64h, o_note_on pulses once.
REQ-031 90 45 64, then 80 40 00 -> o_cmd stays 1; then 80 45 00 -> o_cmd=0 and o_midi stays 45h.
REQ-032 90 45 64, F8 inserted between every byte of 90 48 20 -> o_midi=48h, o_cmd continuous 1, two o_note_on pulses in total.
REQ-033 90 45 64 then 45 00: with MIDI_RUNNING_STATUS_EN, o_cmd=0; without the macro, o_cmd stays 1.
REQ-034 CHANNEL=0, stimulus 91 45 64 and B0 07 7F -> no output change; assert reset after 90 45 -> the following 64 is ignored and o_midi=7Fh.
